// File: rtl/vdma_read_port_arbiter_if.sv
// Per-channel read-request/return signals plus the shared AXI4 AR/R port of the VDMA read arbiter.
// The master modport is the arbiter's view; slave is the environment (channels + memory side).
interface vdma_read_port_arbiter_if #(
    parameter int unsigned NUM       = 4,
    parameter int unsigned IDSIZE    = 4,
    parameter int unsigned ASIZE     = 29,
    parameter int unsigned LSIZE     = 9,
    parameter int unsigned AXI_DSIZE = 256
);
    logic [NUM*ASIZE-1:0] s_araddr;
    logic [NUM*LSIZE-1:0] s_arlen;
    logic [NUM-1:0]       s_arvalid;
    logic [NUM-1:0]       s_arready;
    logic [NUM-1:0]       s_rvalid;
    logic [NUM-1:0]       s_rready;
    logic [NUM-1:0]       s_rlast;
    logic [AXI_DSIZE-1:0] s_rdata;
    logic [1:0]           s_rresp;

    logic [IDSIZE-1:0]    m_axi_arid;
    logic [ASIZE-1:0]     m_axi_araddr;
    logic [LSIZE-1:0]     m_axi_arlen;
    logic                 m_axi_arvalid;
    logic                 m_axi_arready;
    logic [IDSIZE-1:0]    m_axi_rid;
    logic [AXI_DSIZE-1:0] m_axi_rdata;
    logic [1:0]           m_axi_rresp;
    logic                 m_axi_rlast;
    logic                 m_axi_rvalid;
    logic                 m_axi_rready;

    modport master (
        input  s_araddr, s_arlen, s_arvalid, s_rready,
        input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output s_arready, s_rvalid, s_rlast, s_rdata, s_rresp,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready
    );

    modport slave (
        output s_araddr, s_arlen, s_arvalid, s_rready,
        output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  s_arready, s_rvalid, s_rlast, s_rdata, s_rresp,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready
    );
endinterface

// File: rtl/vdma_read_port_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port among NUM VDMA read channels, with a
// per-channel outstanding-burst limit and RID-based return routing.
module vdma_read_port_arbiter #(
    parameter int unsigned NUM       = 4,
    parameter int unsigned IDSIZE    = 4,
    parameter int unsigned ASIZE     = 29,
    parameter int unsigned LSIZE     = 9,
    parameter int unsigned AXI_DSIZE = 256,
    parameter int unsigned MAX_OUT   = 4
) (
    input  logic                       axi_aclk,
    input  logic                       axi_rst,
    vdma_read_port_arbiter_if.master   bus,
    output logic [IDSIZE-1:0]          grant_idx,
    output logic                       id_error
);
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    typedef enum logic [0:0] {StIdle, StAddr} state_e;

    state_e            state_q, state_d;
    logic [IDSIZE-1:0] ptr_q, ptr_d;
    logic [IDSIZE-1:0] arid_q, arid_d;
    logic [ASIZE-1:0]  araddr_q, araddr_d;
    logic [LSIZE-1:0]  arlen_q, arlen_d;
    logic [IDSIZE-1:0] grant_q, grant_d;
    logic              id_error_q, id_error_d;
    logic [CW-1:0]     out_cnt_q [NUM];
    logic [CW-1:0]     out_cnt_d [NUM];

    logic [NUM-1:0]    eligible, win_hot, arid_hot, inc, dec;
    logic              found, sel_ok;
    logic [IDSIZE-1:0] winner;
    logic [ASIZE-1:0]  win_addr;
    logic [LSIZE-1:0]  win_len;

    always_comb begin
        for (int unsigned i = 0; i < NUM; i++) begin
            eligible[i] = bus.s_arvalid[i] && (32'(out_cnt_q[i]) < MAX_OUT);
            arid_hot[i] = (arid_q == IDSIZE'(i));
        end
    end

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_hot  = '0;
        win_addr = '0;
        win_len  = '0;
        // Pass 0 scans channels above ptr, pass 1 wraps to 0..ptr.
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned j = 0; j < NUM; j++) begin
                if (!found && eligible[j] && ((pass == 0) == (j > 32'(ptr_q)))) begin
                    found      = 1'b1;
                    winner     = IDSIZE'(j);
                    win_hot[j] = 1'b1;
                    win_addr   = bus.s_araddr[j*ASIZE +: ASIZE];
                    win_len    = bus.s_arlen[j*LSIZE +: LSIZE];
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        arid_d        = arid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        grant_d       = grant_q;
        inc           = '0;
        bus.s_arready = '0;
        unique case (state_q)
            StIdle: begin
                // Gate on reset so no accept pulse escapes while reset is held.
                if (found && !axi_rst) begin
                    bus.s_arready = win_hot;
                    arid_d        = winner;
                    araddr_d      = win_addr;
                    arlen_d       = win_len;
                    ptr_d         = winner;
                    grant_d       = winner;
                    state_d       = StAddr;
                end
            end
            StAddr: begin
                if (bus.m_axi_arready) begin
                    inc     = arid_hot;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.s_rvalid     = '0;
        bus.s_rlast      = '0;
        bus.m_axi_rready = 1'b1;  // unknown IDs are drained
        dec              = '0;
        sel_ok           = (32'(bus.m_axi_rid) < NUM);
        for (int unsigned i = 0; i < NUM; i++) begin
            if (bus.m_axi_rid == IDSIZE'(i)) begin
                bus.s_rvalid[i]  = bus.m_axi_rvalid;
                bus.s_rlast[i]   = bus.m_axi_rlast;
                bus.m_axi_rready = bus.s_rready[i];
                dec[i]           = bus.m_axi_rvalid && bus.s_rready[i] && bus.m_axi_rlast;
            end
        end
        id_error_d = id_error_q || (bus.m_axi_rvalid && !sel_ok);
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM; i++) begin
            out_cnt_d[i] = out_cnt_q[i];
            if (inc[i] && !dec[i]) begin
                out_cnt_d[i] = out_cnt_q[i] + CW'(1);
            end else if (dec[i] && !inc[i] && (out_cnt_q[i] != '0)) begin
                out_cnt_d[i] = out_cnt_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q    <= StIdle;
            ptr_q      <= IDSIZE'(NUM - 1);
            arid_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            grant_q    <= '0;
            id_error_q <= 1'b0;
            for (int unsigned i = 0; i < NUM; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            arid_q     <= arid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            grant_q    <= grant_d;
            id_error_q <= id_error_d;
            for (int unsigned i = 0; i < NUM; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
            end
        end
    end

    assign bus.m_axi_arvalid = (state_q == StAddr);
    assign bus.m_axi_arid    = arid_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.s_rdata       = bus.m_axi_rdata;
    assign bus.s_rresp       = bus.m_axi_rresp;
    assign grant_idx         = grant_q;
    assign id_error          = id_error_q;
endmodule

// File: tb/tb_vdma_read_port_arbiter.sv
// Scoreboard bench for vdma_read_port_arbiter: expected ARs and R beats are queued as stimulus
// is driven and popped when the DUT completes the corresponding handshake.
module tb_vdma_read_port_arbiter;
    localparam int unsigned NUM     = 4;
    localparam int unsigned IDSIZE  = 4;
    localparam int unsigned ASIZE   = 29;
    localparam int unsigned LSIZE   = 9;
    localparam int unsigned DW      = 256;
    localparam int unsigned MAX_OUT = 4;

    typedef struct {
        logic [IDSIZE-1:0] id;
        logic [ASIZE-1:0]  addr;
        logic [LSIZE-1:0]  len;
    } ar_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [IDSIZE-1:0] grant_idx;
    logic              id_error;
    int                checks = 0;
    int                errors = 0;
    ar_t               ar_exp[$];
    r_t                r_exp[$];

    vdma_read_port_arbiter_if #(
        .NUM(NUM), .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .AXI_DSIZE(DW)
    ) bus ();

    vdma_read_port_arbiter #(
        .NUM(NUM), .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .AXI_DSIZE(DW),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .axi_aclk  (clk),
        .axi_rst   (rst),
        .bus       (bus),
        .grant_idx (grant_idx),
        .id_error  (id_error)
    );

    always #5 clk = ~clk;

    function automatic logic [ASIZE-1:0] ch_addr(int ch);
        return ASIZE'(32'h1000 * (ch + 1) + 32'h40);
    endfunction

    function automatic logic [LSIZE-1:0] ch_len(int ch);
        return LSIZE'(ch + 3);
    endfunction

    function automatic ar_t ch_ar(int ch);
        ar_t e;
        e.id   = IDSIZE'(ch);
        e.addr = ch_addr(ch);
        e.len  = ch_len(ch);
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reqs(logic [NUM-1:0] v);
        bus.s_arvalid = v;
        for (int ch = 0; ch < NUM; ch++) begin
            bus.s_araddr[ch*ASIZE +: ASIZE] = ch_addr(ch);
            bus.s_arlen[ch*LSIZE +: LSIZE]  = ch_len(ch);
        end
    endtask

    task automatic idle_bus();
        set_reqs('0);
        bus.s_rready      = '0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rid     = '0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = '0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_bus();
        ar_exp.delete();
        repeat (2) next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        set_reqs('1);
        bus.m_axi_arready = 1'b1;
        #3;
        checks++; if (bus.m_axi_arvalid !== 1'b0) begin errors++;
            $display("FAIL reset_arvalid: got %0b want 0", bus.m_axi_arvalid); end
        checks++; if ({bus.m_axi_arid, bus.m_axi_araddr, bus.m_axi_arlen} !== '0) begin errors++;
            $display("FAIL reset_ar_regs: got id=%0h addr=%0h len=%0h want 0", bus.m_axi_arid,
                     bus.m_axi_araddr, bus.m_axi_arlen); end
        checks++; if (bus.s_arready !== '0) begin errors++;
            $display("FAIL reset_s_arready: got %b want 0000", bus.s_arready); end
        checks++; if (grant_idx !== '0) begin errors++;
            $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); end
        checks++; if (id_error !== 1'b0) begin errors++;
            $display("FAIL reset_id_error: got %0b want 0", id_error); end
        next_cycle();
        checks++; if ((bus.s_arready !== '0) || (bus.m_axi_arvalid !== 1'b0)) begin errors++;
            $display("FAIL reset_held_edge: got arready=%b arvalid=%0b want 0", bus.s_arready,
                     bus.m_axi_arvalid); end
        idle_bus();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_single();
        ar_t e;
        bus.s_arvalid                   = 4'b0001;
        bus.s_araddr[0 +: ASIZE]        = ASIZE'(32'h100);
        bus.s_arlen[0 +: LSIZE]         = LSIZE'(8);
        e.id = '0; e.addr = ASIZE'(32'h100); e.len = LSIZE'(8);
        ar_exp.push_back(e);
        @(negedge clk);
        checks++; if (bus.s_arready !== 4'b0001) begin errors++;
            $display("FAIL single_grant_pulse: got %b want 0001", bus.s_arready); end
        next_cycle();
        bus.s_arvalid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.m_axi_arvalid, bus.m_axi_arid, bus.m_axi_araddr, bus.m_axi_arlen} !==
                {1'b1, e.id, e.addr, e.len}) begin
                errors++;
                $display("FAIL single_ar_hold: got v=%0b id=%0h addr=%0h len=%0h want 1/%0h/%0h/%0h",
                         bus.m_axi_arvalid, bus.m_axi_arid, bus.m_axi_araddr, bus.m_axi_arlen,
                         e.id, e.addr, e.len);
            end
            checks++; if (bus.s_arready !== '0) begin errors++;
                $display("FAIL single_arready_in_addr: got %b want 0000", bus.s_arready); end
            next_cycle();
        end
        bus.m_axi_arready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.m_axi_arvalid && ar_exp.size() > 0) begin
            e = ar_exp.pop_front();
            if ({bus.m_axi_arid, bus.m_axi_araddr, bus.m_axi_arlen} !== {e.id, e.addr, e.len}) begin
                errors++;
                $display("FAIL single_ar_accept: got id=%0h addr=%0h len=%0h want %0h/%0h/%0h",
                         bus.m_axi_arid, bus.m_axi_araddr, bus.m_axi_arlen, e.id, e.addr, e.len);
            end
        end else begin
            errors++;
            $display("FAIL single_ar_accept: got arvalid=%0b want 1", bus.m_axi_arvalid);
        end
        next_cycle();
        bus.m_axi_arready = 1'b0;
        @(negedge clk);
        checks++; if (bus.m_axi_arvalid !== 1'b0) begin errors++;
            $display("FAIL single_arvalid_drop: got %0b want 0", bus.m_axi_arvalid); end
        checks++; if (grant_idx !== '0) begin errors++;
            $display("FAIL single_grant_idx: got %0d want 0", grant_idx); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        ar_t e;
        int  grants = 0;
        int  last_c = 0;
        int  hs     = 0;
        apply_reset();
        for (int k = 0; k < 5; k++) ar_exp.push_back(ch_ar(k % NUM));
        set_reqs('1);
        bus.m_axi_arready = 1'b1;
        for (int c = 0; c < 20 && hs < 5; c++) begin
            @(negedge clk);
            if (bus.m_axi_arvalid) begin
                checks++; if (bus.s_arready !== '0) begin errors++;
                    $display("FAIL rr_arready_in_addr: got %b want 0000", bus.s_arready); end
            end else if (grants < 5) begin
                checks++;
                if (bus.s_arready !== (NUM'(1) << (grants % NUM))) begin errors++;
                    $display("FAIL rr_grant_order: got %b want %b", bus.s_arready,
                             NUM'(1) << (grants % NUM)); end
                if (grants > 0) begin
                    checks++; if (c - last_c != 2) begin errors++;
                        $display("FAIL rr_spacing: got %0d cycles want 2", c - last_c); end
                end
                last_c = c;
                grants++;
            end
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                hs++;
                checks++;
                if (ar_exp.size() == 0) begin errors++;
                    $display("FAIL rr_unexpected_ar: got id=%0h want none", bus.m_axi_arid);
                end else begin
                    e = ar_exp.pop_front();
                    if ({bus.m_axi_arid, bus.m_axi_araddr, bus.m_axi_arlen, grant_idx} !==
                        {e.id, e.addr, e.len, e.id}) begin
                        errors++;
                        $display("FAIL rr_ar: got id=%0h addr=%0h len=%0h gi=%0h want %0h/%0h/%0h",
                                 bus.m_axi_arid, bus.m_axi_araddr, bus.m_axi_arlen, grant_idx,
                                 e.id, e.addr, e.len);
                    end
                end
            end
            next_cycle();
            if (grants >= 5) set_reqs('0);
        end
        checks++; if (hs != 5) begin errors++;
            $display("FAIL rr_count: got %0d ARs want 5", hs); end
        bus.m_axi_arready = 1'b0;
    endtask

    task automatic test_outstanding();
        ar_t e;
        int  hs     = 0;
        int  beat_c = 16;
        apply_reset();
        for (int k = 0; k < MAX_OUT; k++) ar_exp.push_back(ch_ar(1));
        set_reqs(4'b0010);
        bus.s_rready      = '1;
        bus.m_axi_arready = 1'b1;
        bus.m_axi_rid     = IDSIZE'(1);
        for (int c = 0; c < 28; c++) begin
            bus.m_axi_rvalid = (c == beat_c);
            bus.m_axi_rlast  = (c == beat_c);
            if (c == beat_c) ar_exp.push_back(ch_ar(1));
            @(negedge clk);
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                hs++;
                checks++;
                if (ar_exp.size() == 0) begin errors++;
                    $display("FAIL limit_unexpected_ar: got id=%0h want none", bus.m_axi_arid);
                end else begin
                    e = ar_exp.pop_front();
                    if ({bus.m_axi_arid, bus.m_axi_araddr} !== {e.id, e.addr}) begin errors++;
                        $display("FAIL limit_ar: got id=%0h addr=%0h want %0h/%0h",
                                 bus.m_axi_arid, bus.m_axi_araddr, e.id, e.addr); end
                end
            end
            if (c >= 8 && c < beat_c) begin
                checks++; if (bus.s_arready !== '0) begin errors++;
                    $display("FAIL limit_blocked: got %b want 0000 at c=%0d", bus.s_arready, c); end
            end
            if (c == beat_c) begin
                checks++;
                if ({bus.s_rvalid, bus.s_rlast, bus.m_axi_rready} !== {4'b0010, 4'b0010, 1'b1}) begin
                    errors++;
                    $display("FAIL limit_beat_route: got rv=%b rl=%b rr=%0b want 0010/0010/1",
                             bus.s_rvalid, bus.s_rlast, bus.m_axi_rready);
                end
            end
            if (c == beat_c - 1) begin
                checks++; if (hs != MAX_OUT) begin errors++;
                    $display("FAIL limit_count: got %0d ARs want %0d", hs, MAX_OUT); end
            end
            if (c == beat_c + 2) begin
                checks++; if (hs != MAX_OUT + 1) begin errors++;
                    $display("FAIL limit_reissue: got %0d ARs want %0d", hs, MAX_OUT + 1); end
            end
            next_cycle();
        end
        checks++; if (hs != MAX_OUT + 1) begin errors++;
            $display("FAIL limit_final: got %0d ARs want %0d", hs, MAX_OUT + 1); end
        idle_bus();
    endtask

    task automatic test_r_routing();
        r_t   e;
        int   got    = 0;
        int   pushed = 0;
        logic rdy;
        bus.m_axi_rid    = IDSIZE'(2);
        bus.m_axi_rvalid = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            rdy              = (c % 2 == 1);
            bus.s_rready     = rdy ? 4'b1111 : 4'b1011;
            bus.m_axi_rdata  = {8{32'hD000_0000 + 32'(got)}};
            bus.m_axi_rresp  = 2'(got);
            bus.m_axi_rlast  = (got == 7);
            if (pushed == got) begin
                e.data = bus.m_axi_rdata; e.resp = bus.m_axi_rresp; e.last = (got == 7);
                r_exp.push_back(e);
                pushed++;
            end
            @(negedge clk);
            checks++; if (bus.m_axi_rready !== rdy) begin errors++;
                $display("FAIL route_rready: got %0b want %0b", bus.m_axi_rready, rdy); end
            checks++; if (bus.s_rvalid !== 4'b0100) begin errors++;
                $display("FAIL route_rvalid: got %b want 0100", bus.s_rvalid); end
            if (bus.m_axi_rvalid && bus.m_axi_rready) begin
                e = r_exp.pop_front();
                got++;
                checks++;
                if ({bus.s_rdata, bus.s_rresp, bus.s_rlast} !==
                    {e.data, e.resp, (e.last ? 4'b0100 : 4'b0000)}) begin
                    errors++;
                    $display("FAIL route_beat: got data=%h resp=%0h last=%b want %h/%0h/%0b",
                             bus.s_rdata, bus.s_rresp, bus.s_rlast, e.data, e.resp, e.last);
                end
            end
            next_cycle();
        end
        checks++; if (got != 8) begin errors++;
            $display("FAIL route_count: got %0d beats want 8", got); end
        idle_bus();
    endtask

    task automatic test_id_error();
        @(negedge clk);
        checks++; if (id_error !== 1'b0) begin errors++;
            $display("FAIL iderr_initial: got %0b want 0", id_error); end
        next_cycle();
        bus.m_axi_rid    = IDSIZE'(5);
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rlast  = 1'b1;
        bus.s_rready     = '0;
        @(negedge clk);
        checks++;
        if ({bus.m_axi_rready, bus.s_rvalid, bus.s_rlast} !== {1'b1, 4'b0000, 4'b0000}) begin
            errors++;
            $display("FAIL iderr_drain: got rr=%0b rv=%b rl=%b want 1/0000/0000",
                     bus.m_axi_rready, bus.s_rvalid, bus.s_rlast);
        end
        next_cycle();
        idle_bus();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (id_error !== 1'b1) begin errors++;
                $display("FAIL iderr_sticky: got %0b want 1 at c=%0d", id_error, c); end
            next_cycle();
        end
    endtask

    task automatic test_simultaneous();
        ar_t e;
        int  hs     = 0;
        int  fire_c = -1;
        bit  armed  = 1'b0;
        bit  fired  = 1'b0;
        apply_reset();
        for (int k = 0; k < 3; k++) ar_exp.push_back(ch_ar(3));
        set_reqs(4'b1000);
        bus.s_rready  = '1;
        bus.m_axi_rid = IDSIZE'(3);
        for (int c = 0; c < 30; c++) begin
            if (armed) begin
                armed  = 1'b0;
                fired  = 1'b1;
                fire_c = c;
                ar_exp.push_back(ch_ar(3));
                ar_exp.push_back(ch_ar(3));
            end
            bus.m_axi_rvalid  = (c == fire_c);
            bus.m_axi_rlast   = (c == fire_c);
            bus.m_axi_arready = (hs < 3) || fired;
            @(negedge clk);
            if (c == fire_c) begin
                checks++;
                if ({bus.m_axi_arvalid, bus.s_rvalid, bus.m_axi_rready} !== {1'b1, 4'b1000, 1'b1})
                begin
                    errors++;
                    $display("FAIL sim_both_events: got av=%0b rv=%b rr=%0b want 1/1000/1",
                             bus.m_axi_arvalid, bus.s_rvalid, bus.m_axi_rready);
                end
            end
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                hs++;
                checks++;
                if (ar_exp.size() == 0) begin errors++;
                    $display("FAIL sim_unexpected_ar: got id=%0h want none", bus.m_axi_arid);
                end else begin
                    e = ar_exp.pop_front();
                    if (bus.m_axi_arid !== e.id) begin errors++;
                        $display("FAIL sim_ar: got id=%0h want %0h", bus.m_axi_arid, e.id); end
                end
            end else if (hs == 3 && bus.m_axi_arvalid && !fired) begin
                armed = 1'b1;
            end
            next_cycle();
        end
        checks++; if (hs != 5 || ar_exp.size() != 0) begin errors++;
            $display("FAIL sim_count: got %0d ARs want 5", hs); end
        idle_bus();
    endtask

    task automatic test_reset_mid();
        ar_t e;
        int  hs   = 0;
        bit  seen = 1'b0;
        set_reqs(4'b0001);
        bus.m_axi_arready = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = bus.m_axi_arvalid;
            if (!seen) next_cycle();
        end
        checks++; if (!seen) begin errors++;
            $display("FAIL rstmid_reach_addr: got arvalid=0 want 1"); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.m_axi_arvalid !== 1'b0) begin errors++;
            $display("FAIL rstmid_arvalid: got %0b want 0", bus.m_axi_arvalid); end
        set_reqs('0);
        ar_exp.delete();
        repeat (2) next_cycle();
        rst = 1'b0;
        bus.m_axi_rid    = '0;
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rlast  = 1'b1;
        bus.s_rready     = '1;
        @(negedge clk);
        checks++; if (bus.s_rvalid !== 4'b0001) begin errors++;
            $display("FAIL rstmid_stray_route: got %b want 0001", bus.s_rvalid); end
        next_cycle();
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
        set_reqs('1);
        bus.m_axi_arready = 1'b1;
        for (int k = 0; k < MAX_OUT; k++) ar_exp.push_back(ch_ar(0));
        @(negedge clk);
        checks++; if (bus.s_arready !== 4'b0001) begin errors++;
            $display("FAIL rstmid_first_winner: got %b want 0001", bus.s_arready); end
        next_cycle();
        set_reqs(4'b0001);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                hs++;
                checks++;
                if (ar_exp.size() == 0) begin errors++;
                    $display("FAIL rstmid_unexpected_ar: got id=%0h want none", bus.m_axi_arid);
                end else begin
                    e = ar_exp.pop_front();
                    if ({bus.m_axi_arid, bus.m_axi_araddr} !== {e.id, e.addr}) begin errors++;
                        $display("FAIL rstmid_ar: got id=%0h addr=%0h want %0h/%0h",
                                 bus.m_axi_arid, bus.m_axi_araddr, e.id, e.addr); end
                end
            end
            next_cycle();
        end
        checks++; if (hs != MAX_OUT) begin errors++;
            $display("FAIL rstmid_counter_clear: got %0d ARs want %0d", hs, MAX_OUT); end
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_outstanding();
        test_r_routing();
        test_id_error();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
